// File: rtl/elevator_scan_ctrl.sv
// SCAN-scheduled elevator controller: latched car/hall calls, timed travel and door dwell,
// emergency stop. engine/doors/cur_floor are registered; pending is the OR of the call latches.
module elevator_scan_ctrl #(
  parameter int FLOORS     = 8,
  parameter int FW         = 4,
  parameter int TRAVEL_CYC = 4,
  parameter int DOOR_CYC   = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              auth_ok,
  input  logic [FLOORS-1:0] int_req,
  input  logic [FLOORS-1:0] ext_up_req,
  input  logic [FLOORS-1:0] ext_dn_req,
  input  logic              estop,
  output logic [1:0]        engine,
  output logic [2:0]        doors,
  output logic [FW-1:0]     cur_floor,
  output logic [FLOORS-1:0] pending
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] MOVE_UP    = 3'd1;
  localparam logic [2:0] MOVE_DN    = 3'd2;
  localparam logic [2:0] DOOR_OPEN  = 3'd3;
  localparam logic [2:0] DOOR_CLOSE = 3'd4;
  localparam logic [2:0] ESTOP      = 3'd5;

  localparam int TW = (TRAVEL_CYC > 1) ? $clog2(TRAVEL_CYC) : 1;
  localparam int DW = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;

  logic [2:0]        state, nxt_state;
  logic              dir, nxt_dir;
  logic [FW-1:0]     nxt_floor, up_floor, dn_floor;
  logic [TW-1:0]     tcnt, nxt_tcnt;
  logic [DW-1:0]     dcnt, nxt_dcnt, dwell_eff;
  logic [FLOORS-1:0] int_calls, up_calls, dn_calls;
  logic [FLOORS-1:0] nxt_int, nxt_up, nxt_dn;
  logic [FLOORS-1:0] int_in, keep, clear, cur_oh;
  logic              reload;

  function automatic logic [FLOORS-1:0] onehot(input logic [FW-1:0] f);
    logic [FLOORS-1:0] o;
    for (int i = 0; i < FLOORS; i++) o[i] = (i == int'(f));
    return o;
  endfunction

  function automatic logic has_call(input logic [FLOORS-1:0] v, input logic [FW-1:0] f);
    return |(v & onehot(f));
  endfunction

  function automatic logic any_above(input logic [FLOORS-1:0] v, input logic [FW-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++) if (i > int'(f) && v[i]) r = 1'b1;
    return r;
  endfunction

  function automatic logic any_below(input logic [FLOORS-1:0] v, input logic [FW-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < FLOORS; i++) if (i < int'(f) && v[i]) r = 1'b1;
    return r;
  endfunction

  function automatic logic [1:0] engine_of(input logic [2:0] s);
    case (s)
      MOVE_UP: return 2'b01;
      MOVE_DN: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [2:0] doors_of(input logic [2:0] s);
    case (s)
      DOOR_OPEN:  return 3'b010;
      DOOR_CLOSE: return 3'b100;
      default:    return 3'b001;
    endcase
  endfunction

  assign pending  = int_calls | up_calls | dn_calls;
  assign up_floor = cur_floor + FW'(1);
  assign dn_floor = cur_floor - FW'(1);
  assign cur_oh   = onehot(cur_floor);

  // A press at the open floor restarts the dwell instead of latching a call.
  assign int_in    = auth_ok ? int_req : '0;
  assign keep      = (state == DOOR_OPEN) ? ~cur_oh : '1;
  assign reload    = (state == DOOR_OPEN) && |((int_in | ext_up_req | ext_dn_req) & cur_oh);
  assign dwell_eff = reload ? '0 : dcnt;

  always_comb begin
    nxt_state = state;
    nxt_dir   = dir;
    nxt_floor = cur_floor;
    nxt_tcnt  = tcnt;
    nxt_dcnt  = dcnt;
    if (estop) begin
      nxt_state = ESTOP;
      nxt_tcnt  = '0;
      nxt_dcnt  = '0;
    end else begin
      case (state)
        IDLE: begin
          nxt_tcnt = '0;
          nxt_dcnt = '0;
          if (has_call(pending, cur_floor)) begin
            nxt_state = DOOR_OPEN;
          end else if (any_above(pending, cur_floor)) begin
            nxt_state = MOVE_UP;
            nxt_dir   = 1'b1;
          end else if (any_below(pending, cur_floor)) begin
            nxt_state = MOVE_DN;
            nxt_dir   = 1'b0;
          end
        end
        MOVE_UP: begin
          if (tcnt == TW'(TRAVEL_CYC - 1)) begin
            nxt_tcnt  = '0;
            nxt_floor = up_floor;
            if (has_call(pending, up_floor)) begin
              nxt_state = DOOR_OPEN;
              nxt_dcnt  = '0;
            end else if (!any_above(pending, up_floor)) begin
              nxt_state = IDLE;
            end
          end else begin
            nxt_tcnt = tcnt + TW'(1);
          end
        end
        MOVE_DN: begin
          if (tcnt == TW'(TRAVEL_CYC - 1)) begin
            nxt_tcnt  = '0;
            nxt_floor = dn_floor;
            if (has_call(pending, dn_floor)) begin
              nxt_state = DOOR_OPEN;
              nxt_dcnt  = '0;
            end else if (!any_below(pending, dn_floor)) begin
              nxt_state = IDLE;
            end
          end else begin
            nxt_tcnt = tcnt + TW'(1);
          end
        end
        DOOR_OPEN: begin
          // The reload cycle itself counts as the first cycle of the renewed dwell.
          if (dwell_eff == DW'(DOOR_CYC - 1)) begin
            nxt_state = DOOR_CLOSE;
            nxt_dcnt  = '0;
          end else begin
            nxt_dcnt = dwell_eff + DW'(1);
          end
        end
        DOOR_CLOSE: begin
          nxt_tcnt = '0;
          if (dir && any_above(pending, cur_floor)) begin
            nxt_state = MOVE_UP;
          end else if (!dir && any_below(pending, cur_floor)) begin
            nxt_state = MOVE_DN;
          end else if (any_below(pending, cur_floor)) begin
            nxt_state = MOVE_DN;
            nxt_dir   = 1'b0;
          end else if (any_above(pending, cur_floor)) begin
            nxt_state = MOVE_UP;
            nxt_dir   = 1'b1;
          end else begin
            nxt_state = IDLE;
          end
        end
        ESTOP: begin
          nxt_state = IDLE;
          nxt_tcnt  = '0;
          nxt_dcnt  = '0;
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  // Clearing on door-open entry wins over a same-cycle press for that floor.
  assign clear   = (nxt_state == DOOR_OPEN && state != DOOR_OPEN) ? onehot(nxt_floor) : '0;
  assign nxt_int = (int_calls | (int_in & keep)) & ~clear;
  assign nxt_up  = (up_calls | (ext_up_req & keep)) & ~clear;
  assign nxt_dn  = (dn_calls | (ext_dn_req & keep)) & ~clear;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      dir       <= 1'b1;
      cur_floor <= '0;
      tcnt      <= '0;
      dcnt      <= '0;
      int_calls <= '0;
      up_calls  <= '0;
      dn_calls  <= '0;
      engine    <= 2'b00;
      doors     <= 3'b001;
    end else begin
      state     <= nxt_state;
      dir       <= nxt_dir;
      cur_floor <= nxt_floor;
      tcnt      <= nxt_tcnt;
      dcnt      <= nxt_dcnt;
      int_calls <= nxt_int;
      up_calls  <= nxt_up;
      dn_calls  <= nxt_dn;
      engine    <= engine_of(nxt_state);
      doors     <= doors_of(nxt_state);
    end
  end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl: per-cycle expectations queued on stimulus,
// popped and compared one cycle after each active edge.
module tb_elevator_scan_ctrl;

  localparam int FLOORS = 8;
  localparam int FW     = 4;
  localparam int TRAVEL = 4;
  localparam int DOOR   = 3;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              auth_ok;
  logic [FLOORS-1:0] int_req, ext_up_req, ext_dn_req;
  logic              estop;
  logic [1:0]        engine;
  logic [2:0]        doors;
  logic [FW-1:0]     cur_floor;
  logic [FLOORS-1:0] pending;

  int    ncmp  = 0;
  int    nfail = 0;
  string phase = "init";

  typedef struct packed {
    logic [1:0] eng;
    logic [2:0] drs;
    logic [3:0] flr;
    logic [7:0] pnd;
  } exp_t;

  exp_t sb[$];

  elevator_scan_ctrl #(
    .FLOORS(FLOORS), .FW(FW), .TRAVEL_CYC(TRAVEL), .DOOR_CYC(DOOR)
  ) dut (
    .CLK(CLK), .RST(RST), .auth_ok(auth_ok), .int_req(int_req),
    .ext_up_req(ext_up_req), .ext_dn_req(ext_dn_req), .estop(estop),
    .engine(engine), .doors(doors), .cur_floor(cur_floor), .pending(pending)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s/%s t=%0t observed=%0h expected=%0h", phase, tag, $time, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] e, input logic [2:0] d, input int f, input logic [7:0] p);
    exp_t x;
    x.eng = e;
    x.drs = d;
    x.flr = 4'(f);
    x.pnd = p;
    sb.push_back(x);
  endtask

  task automatic observe();
    exp_t x;
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      x = sb.pop_front();
      chk("engine", 32'(engine), 32'(x.eng));
      chk("doors", 32'(doors), 32'(x.drs));
      chk("cur_floor", 32'(cur_floor), 32'(x.flr));
      chk("pending", 32'(pending), 32'(x.pnd));
    end
  endtask

  task automatic cyc(input logic [1:0] e, input logic [2:0] d, input int f, input logic [7:0] p);
    push(e, d, f, p);
    @(posedge CLK);
    #1;
    observe();
  endtask

  task automatic move(input bit up, input int from, input int nfl, input logic [7:0] p);
    for (int k = 0; k < nfl; k++)
      for (int c = 0; c < TRAVEL; c++)
        cyc(up ? 2'b01 : 2'b10, 3'b001, up ? from + k : from - k, p);
  endtask

  task automatic dwell(input int fl, input logic [7:0] p);
    for (int c = 0; c < DOOR; c++) cyc(2'b00, 3'b010, fl, p);
    cyc(2'b00, 3'b100, fl, p);
  endtask

  // Structural invariants checked every cycle out of reset.
  always @(negedge CLK) begin
    if (RST) begin
      chk("floor_in_range", 32'(int'(cur_floor) < FLOORS), 32'd1);
      chk("engine_legal", 32'(engine != 2'b11), 32'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    auth_ok = 0; int_req = '0; ext_up_req = '0; ext_dn_req = '0; estop = 0;
    #2 RST = 1'b0;
    phase = "reset";
    repeat (2) @(posedge CLK);
    #1;
    push(2'b00, 3'b001, 0, 8'h00); observe();
    RST = 1'b1;

    phase = "t1_up3";
    auth_ok = 1; int_req = 8'h08;
    cyc(2'b00, 3'b001, 0, 8'h08);
    int_req = '0;
    move(1, 0, 3, 8'h08);
    dwell(3, 8'h00);
    cyc(2'b00, 3'b001, 3, 8'h00);

    phase = "t2_auth";
    auth_ok = 0; int_req = 8'h20;
    cyc(2'b00, 3'b001, 3, 8'h00);
    cyc(2'b00, 3'b001, 3, 8'h00);
    auth_ok = 1;
    cyc(2'b00, 3'b001, 3, 8'h20);
    int_req = '0;
    move(1, 3, 2, 8'h20);
    dwell(5, 8'h00);
    cyc(2'b00, 3'b001, 5, 8'h00);

    phase = "t3_home";
    ext_up_req = 8'h01;
    cyc(2'b00, 3'b001, 5, 8'h01);
    ext_up_req = '0;
    move(0, 5, 5, 8'h01);
    dwell(0, 8'h00);
    cyc(2'b00, 3'b001, 0, 8'h00);

    phase = "t3_scan";
    int_req = 8'h20;
    cyc(2'b00, 3'b001, 0, 8'h20);
    int_req = '0;
    move(1, 0, 3, 8'h20);
    cyc(2'b01, 3'b001, 3, 8'h20);
    ext_dn_req = 8'h02;
    cyc(2'b01, 3'b001, 3, 8'h22);
    ext_dn_req = '0;
    cyc(2'b01, 3'b001, 3, 8'h22);
    cyc(2'b01, 3'b001, 3, 8'h22);
    move(1, 4, 1, 8'h22);
    dwell(5, 8'h02);
    move(0, 5, 4, 8'h02);
    dwell(1, 8'h00);
    cyc(2'b00, 3'b001, 1, 8'h00);

    phase = "t4_reload";
    int_req = 8'h04;
    cyc(2'b00, 3'b001, 1, 8'h04);
    int_req = '0;
    move(1, 1, 1, 8'h04);
    cyc(2'b00, 3'b010, 2, 8'h00);
    cyc(2'b00, 3'b010, 2, 8'h00);
    ext_up_req = 8'h04;
    cyc(2'b00, 3'b010, 2, 8'h00);
    ext_up_req = '0;
    cyc(2'b00, 3'b010, 2, 8'h00);
    cyc(2'b00, 3'b100, 2, 8'h00);
    cyc(2'b00, 3'b001, 2, 8'h00);

    phase = "t5_estop";
    ext_up_req = 8'h01;
    cyc(2'b00, 3'b001, 2, 8'h01);
    ext_up_req = '0;
    move(0, 2, 2, 8'h01);
    dwell(0, 8'h00);
    cyc(2'b00, 3'b001, 0, 8'h00);
    int_req = 8'h10;
    cyc(2'b00, 3'b001, 0, 8'h10);
    int_req = '0;
    cyc(2'b01, 3'b001, 0, 8'h10);
    cyc(2'b01, 3'b001, 0, 8'h10);
    estop = 1;
    cyc(2'b00, 3'b001, 0, 8'h10);
    cyc(2'b00, 3'b001, 0, 8'h10);
    estop = 0;
    cyc(2'b00, 3'b001, 0, 8'h10);
    move(1, 0, 4, 8'h10);
    dwell(4, 8'h00);
    cyc(2'b00, 3'b001, 4, 8'h00);

    phase = "t6_async_rst";
    int_req = 8'h80; ext_dn_req = 8'h02;
    cyc(2'b00, 3'b001, 4, 8'h82);
    int_req = '0; ext_dn_req = '0;
    cyc(2'b01, 3'b001, 4, 8'h82);
    cyc(2'b01, 3'b001, 4, 8'h82);
    #2 RST = 1'b0;
    #1;
    push(2'b00, 3'b001, 0, 8'h00); observe();
    @(posedge CLK);
    #1 RST = 1'b1;
    cyc(2'b00, 3'b001, 0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/elevator_scan_ctrl.md
Name: elevator_scan_ctrl

Overview:
- Parametrised successor to the fixed 3-floor elevator controller.
- Supports FLOORS floors, latched interior and exterior (up/down) call registers, SCAN (sweep) scheduling, and programmable travel and door-dwell timers.
- Adds an emergency-stop mode and gates interior calls on an auth_ok flag driven by the keypad/login block.
- Sits between the keypad/auth front end and the engine/door actuators.

Parameters:
- FLOORS, 8: number of floors; legal range 2..16.
- FW, 4: floor index width; must satisfy 2^FW >= FLOORS.
- TRAVEL_CYC, 4: clock cycles to travel one floor; must be >= 1.
- DOOR_CYC, 3: clock cycles doors stay open; must be >= 1.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- auth_ok  in  1  interior calls are accepted only while high.
- int_req  in  FLOORS  interior car-call buttons, one bit per floor.
- ext_up_req  in  FLOORS  hall up-call buttons.
- ext_dn_req  in  FLOORS  hall down-call buttons.
- estop  in  1  emergency stop, level-sensitive.
- engine  out  2  00 stop, 01 up, 10 down; 11 is never driven.
- doors  out  3  one-hot: 001 closed, 010 open, 100 closing.
- cur_floor  out  FW  current floor index.
- pending  out  FLOORS  OR of all latched calls, per floor.

Behaviour:
- Reset (RST=0, asynchronous): state IDLE, engine=00, doors=001, cur_floor=0, all call registers 0, timers 0.
- Call latching:
  - On every rising edge, a high input bit sets the matching call-register bit.
  - int_req bits are ignored while auth_ok=0.
  - A call for cur_floor that arrives in DOOR_OPEN does not latch. Instead it reloads the dwell timer.
- All call bits for a floor are cleared on the cycle the FSM enters DOOR_OPEN at that floor.
- State IDLE:
  - pending[cur_floor]=1 -> DOOR_OPEN.
  - Otherwise, any pending above -> MOVE_UP.
  - Otherwise, any pending below -> MOVE_DN.
  - Otherwise stay in IDLE.
  - Up is preferred whenever calls exist both above and below.
- State MOVE_UP / MOVE_DN:
  - engine=01 / 10; the travel counter counts TRAVEL_CYC cycles.
  - When the count completes, cur_floor increments / decrements and the counter clears.
  - On arrival, pending at the new floor -> DOOR_OPEN (engine=00 in that same cycle).
  - Otherwise keep moving if any call remains ahead; if none remains, go to IDLE.
  - cur_floor never moves above FLOORS-1 or below 0; a request to move past an end is impossible by construction and is asserted in verification.
- State DOOR_OPEN: doors=010, engine=00; stays DOOR_CYC cycles, then goes to DOOR_CLOSE.
- State DOOR_CLOSE:
  - doors=100 for exactly 1 cycle.
  - Then continue in the previous sweep direction if any call remains ahead.
  - Else reverse if any call remains behind.
  - Else go to IDLE.
- SCAN rule: direction never reverses while any call remains ahead in the current direction.
- Emergency stop:
  - estop=1, sampled synchronously, enters ESTOP from any state on the next edge.
  - In ESTOP: engine=00, doors=001, travel and dwell counters cleared.
  - A partial floor of travel is discarded; cur_floor keeps the last completed floor.
  - Call registers are retained, and new calls still latch.
  - When estop returns to 0, go to IDLE on the next edge.
- Simultaneous events:
  - estop has priority over arrival, door timeout and new calls.
  - A call latching in the same cycle as its floor is cleared on door-open leaves the bit cleared.
- Reset asserted mid-operation forces the reset values immediately, asynchronously.
- Outputs are registered; engine and doors change only on clock edges, except under reset.

Test Plan:
1. Reset with FLOORS=8, TRAVEL_CYC=4, DOOR_CYC=3; pulse int_req=00001000, auth_ok=1 -> engine=01 for 12 cycles, cur_floor steps 1, 2, 3; then doors=010 for 3 cycles, 100 for 1 cycle, 001; back to IDLE; pending=0.
2. auth_ok=0 while int_req=00100000 -> no latch, pending=0, engine stays 00. Repeat with auth_ok=1 -> car travels to floor 5.
3. Car at floor 3 moving up with calls at floors 5 and 1 -> stops at 5 first (doors open), then engine=10 and stops at 1; the sweep never reverses before reaching 5.
4. During DOOR_OPEN at floor 2, press ext_up_req[2] in the second dwell cycle -> dwell timer restarts, giving doors=010 for 4 consecutive cycles total.
5. estop=1 two cycles into travel from floor 0 to floor 4 -> next edge engine=00, doors=001, cur_floor=0. Release estop -> IDLE, then a full 4x4 cycles of travel to floor 4.
6. Assert RST low mid-travel with pending calls -> engine=00, doors=001, cur_floor=0 and pending=0 immediately, before the next clock edge.
